ds1302_bit_engine: RTL and testbench
====================================

DS1302_BIT_ENGINE -- requirements
Module: ds1302_bit_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, clk cycles per SCLK half-period (range 2..255).
REQ-002 SHALL have parameter CE_SETUP, default 200, clk cycles from CE rise to first SCLK rise.
REQ-003 SHALL have parameter CE_HOLD, default 200, clk cycles from last SCLK fall to CE fall.
REQ-004 SHALL have parameter CE_REC, default 200, clk cycles CE held low before ack.
REQ-005 SHALL be one clock; reset is asynchronous and active-high:
- clk  in  1  system clock
- rst  in  1  async active-high reset
REQ-006 SHALL have these ports:
- cmd_write  in  1  write request, level, held until ack
- cmd_read  in  1  read request, level, held until ack
- write_addr  in  8  register command byte for write
- write_data  in  8  byte to write
- read_addr  in  8  register command byte for read
- cmd_write_ack  out  1  one-cycle write-done pulse
- cmd_read_ack  out  1  one-cycle read-done pulse
- read_data  out  8  byte read, valid from the ack cycle
- ds1302_ce  out  1  chip enable
- ds1302_sclk  out  1  serial clock
- ds1302_io  inout  1  bidirectional serial data

Function
REQ-007 SHALL implement states IDLE, SETUP, SHIFT, HOLD, REC and ACK.
REQ-008 IDLE: ce=0, sclk=0, io released (Z); on a cycle with cmd_write=1 or cmd_read=1, latch the operation and address/data, then go to SETUP.
REQ-009 Simultaneous cmd_write and cmd_read in IDLE SHALL select write; read stays pending and is served after that write's ack.
REQ-010 Latched command byte SHALL force bit0: write_addr[0] sent as 0, read_addr[0] sent as 1; bits 7..1 pass unchanged.
REQ-011 SETUP: ce=1, sclk=0 for CE_SETUP cycles, io driven with command bit0, then go to SHIFT.
REQ-012 SHIFT: 16 bit slots, counter 0..15; each slot = CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1.
REQ-013 Slots 0..7: drive command byte LSB first, updated at the start of the sclk-low half.
REQ-014 Write, slots 8..15: drive write_data LSB first in the same way.
REQ-015 Read, slots 8..15: io released from the first cycle of slot 8; sample ds1302_io on the clk edge where sclk goes 0->1; sampled bits fill read_data LSB first.
REQ-016 After slot 15's high half: go to HOLD with sclk=0 and io released; ce=1 for CE_HOLD cycles; then REC.
REQ-017 REC: ce=0 for CE_REC cycles, then ACK.
REQ-018 ACK: for one cycle, assert cmd_write_ack or cmd_read_ack (matching the latched op), then IDLE; cmd inputs ignored in ACK.
REQ-019 read_data SHALL be updated only in the read ACK cycle and otherwise hold; write leaves it unchanged.
REQ-020 Ack SHALL occur exactly 1+CE_SETUP+32*CLK_DIV+CE_HOLD+CE_REC cycles after the edge that samples cmd in IDLE.
REQ-021 Input changes on cmd/addr/data after latching SHALL NOT affect the transaction in progress.
REQ-022 Dropping cmd mid-transaction SHALL NOT abort; transaction completes and still pulses ack.
REQ-023 ds1302_sclk and ds1302_ce SHALL be driven from registers (glitch-free).

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, ce=0, sclk=0, io released, both acks=0, read_data=8'h00, and clear counters and latches.
REQ-025 Reset mid-transaction SHALL abandon it with no ack; the first cmd after reset starts a fresh transaction.

Verification (CLK_DIV=2, CE_SETUP=4, CE_HOLD=4, CE_REC=4)
REQ-026 Write: cmd_write, write_addr=8'h80, write_data=8'h59 -> io bits 0,0,0,0,0,0,0,1 then 1,0,0,1,1,0,1,0 at sclk rises; cmd_write_ack at cycle 77; ce high 4+64+4 cycles.
REQ-027 Read: cmd_read, read_addr=8'h80, model returns 8'h37 on sclk falls from slot 8 -> sent addr 8'h81, io Z from slot 8, read_data=8'h37 with cmd_read_ack at cycle 77.
REQ-028 Both cmd_write and cmd_read in the same IDLE cycle -> write ack first, then read transaction, read ack 77 cycles after the read starts.
REQ-029 rst pulse at slot 10 of a write -> ce=0, sclk=0, io Z in the same cycle, no ack; next cmd_read completes normally.
REQ-030 Back-to-back: cmd held through ack, then re-asserted next cycle with new addr -> second transaction uses new addr; ce low >=4 cycles between transactions.

Source files
------------

// File: rtl/ds1302_bit_engine_if.sv
// ----------------------------------------------------------------------------
// ds1302_bit_engine_if
// Command/response bundle between a host and the DS1302 bit engine.
//   cmd_write / cmd_read : level requests, held by the host until acked
//   write_addr / write_data / read_addr : operands, latched when the
//                          engine accepts a request
//   cmd_write_ack / cmd_read_ack : one-cycle completion pulses
//   read_data            : last byte read, valid from the read ack cycle
// Modports: master = host side, slave = engine side.
// ----------------------------------------------------------------------------
interface ds1302_bit_engine_if;
    logic       cmd_write;
    logic       cmd_read;
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic [7:0] read_addr;
    logic       cmd_write_ack;
    logic       cmd_read_ack;
    logic [7:0] read_data;

    modport master (
        output cmd_write, cmd_read, write_addr, write_data, read_addr,
        input  cmd_write_ack, cmd_read_ack, read_data
    );

    modport slave (
        input  cmd_write, cmd_read, write_addr, write_data, read_addr,
        output cmd_write_ack, cmd_read_ack, read_data
    );
endinterface

// File: rtl/ds1302_bit_engine.sv
// ----------------------------------------------------------------------------
// ds1302_bit_engine
// Serialises one DS1302 register access (command byte + data byte) over the
// 3-wire CE/SCLK/IO link and reports completion with a one-cycle ack.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus          ds1302_bit_engine_if.slave (requests, operands, acks, read_data)
//   ds1302_ce    chip enable (registered)
//   ds1302_sclk  serial clock (registered)
//   ds1302_io    bidirectional serial data
//
// Transaction timeline (cycles after the accepting edge):
//   SETUP CE_SETUP | SHIFT 16 slots x 2*CLK_DIV | HOLD CE_HOLD | REC CE_REC | ACK 1
// ----------------------------------------------------------------------------
module ds1302_bit_engine #(
    parameter int unsigned CLK_DIV  = 50,
    parameter int unsigned CE_SETUP = 200,
    parameter int unsigned CE_HOLD  = 200,
    parameter int unsigned CE_REC   = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    ds1302_bit_engine_if.slave   bus,
    output logic                 ds1302_ce,
    output logic                 ds1302_sclk,
    inout  wire                  ds1302_io
);

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CE_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CE_HOLD - 1);
    localparam logic [15:0] REC_LAST   = 16'(CE_REC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        REC,
        ACK
    } state_t;

    state_t      state_reg,     state_next;
    logic [15:0] cnt_reg,       cnt_next;
    logic [3:0]  slot_reg,      slot_next;
    logic        half_reg,      half_next;      // 0 = sclk-low half, 1 = high half
    logic        op_read_reg,   op_read_next;
    logic        pend_read_reg, pend_read_next; // read deferred behind a write
    logic [7:0]  cmd_byte_reg,  cmd_byte_next;
    logic [7:0]  wdata_reg,     wdata_next;
    logic [7:0]  rx_reg;
    logic [7:0]  read_data_reg;

    logic        ce_reg,     ce_next;
    logic        sclk_reg,   sclk_next;
    logic        io_oe_reg,  io_oe_next;
    logic        io_out_reg, io_out_next;
    logic        wack_reg,   wack_next;
    logic        rack_reg,   rack_next;

    logic        sample_en;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        slot_next      = slot_reg;
        half_next      = half_reg;
        op_read_next   = op_read_reg;
        pend_read_next = pend_read_reg;
        cmd_byte_next  = cmd_byte_reg;
        wdata_next     = wdata_reg;

        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                slot_next = '0;
                half_next = 1'b0;
                // A read that lost arbitration to a write is served first,
                // before any new request is looked at.
                if (pend_read_reg) begin
                    op_read_next   = 1'b1;
                    pend_read_next = 1'b0;
                    cmd_byte_next  = bus.read_addr | 8'h01;
                    state_next     = SETUP;
                end else if (bus.cmd_write) begin
                    op_read_next   = 1'b0;
                    pend_read_next = bus.cmd_read;
                    cmd_byte_next  = bus.write_addr & 8'hFE;
                    wdata_next     = bus.write_data;
                    state_next     = SETUP;
                end else if (bus.cmd_read) begin
                    op_read_next   = 1'b1;
                    cmd_byte_next  = bus.read_addr | 8'h01;
                    state_next     = SETUP;
                end
            end

            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    cnt_next   = '0;
                    slot_next  = '0;
                    half_next  = 1'b0;
                    state_next = SHIFT;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            SHIFT: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (!half_reg) begin
                        half_next = 1'b1;
                    end else begin
                        half_next = 1'b0;
                        if (slot_reg == 4'd15) begin
                            state_next = HOLD;
                        end else begin
                            slot_next = slot_reg + 4'd1;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    state_next = REC;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            REC: begin
                if (cnt_reg == REC_LAST) begin
                    cnt_next   = '0;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            ACK: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pin values decoded from the *next* state so that they can be
    // registered in step with the state and still line up with it.
    // ------------------------------------------------------------------
    always_comb begin
        ce_next     = 1'b0;
        sclk_next   = 1'b0;
        io_oe_next  = 1'b0;
        io_out_next = 1'b0;
        wack_next   = 1'b0;
        rack_next   = 1'b0;

        case (state_next)
            SETUP: begin
                ce_next     = 1'b1;
                io_oe_next  = 1'b1;
                io_out_next = cmd_byte_next[0];
            end
            SHIFT: begin
                ce_next   = 1'b1;
                sclk_next = half_next;
                if (!slot_next[3]) begin
                    io_oe_next  = 1'b1;
                    io_out_next = cmd_byte_next[slot_next[2:0]];
                end else if (!op_read_next) begin
                    io_oe_next  = 1'b1;
                    io_out_next = wdata_next[slot_next[2:0]];
                end
            end
            HOLD: begin
                ce_next = 1'b1;
            end
            ACK: begin
                wack_next = !op_read_next;
                rack_next = op_read_next;
            end
            default: begin
            end
        endcase
    end

    // Sample IO on the edge where SCLK goes 0->1 during the data slots of a read.
    assign sample_en = (state_reg == SHIFT) && !half_reg && (cnt_reg == DIV_LAST)
                       && slot_reg[3] && op_read_reg;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            slot_reg      <= '0;
            half_reg      <= 1'b0;
            op_read_reg   <= 1'b0;
            pend_read_reg <= 1'b0;
            cmd_byte_reg  <= '0;
            wdata_reg     <= '0;
            rx_reg        <= '0;
            read_data_reg <= '0;
            ce_reg        <= 1'b0;
            sclk_reg      <= 1'b0;
            io_oe_reg     <= 1'b0;
            io_out_reg    <= 1'b0;
            wack_reg      <= 1'b0;
            rack_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            slot_reg      <= slot_next;
            half_reg      <= half_next;
            op_read_reg   <= op_read_next;
            pend_read_reg <= pend_read_next;
            cmd_byte_reg  <= cmd_byte_next;
            wdata_reg     <= wdata_next;
            ce_reg        <= ce_next;
            sclk_reg      <= sclk_next;
            io_oe_reg     <= io_oe_next;
            io_out_reg    <= io_out_next;
            wack_reg      <= wack_next;
            rack_reg      <= rack_next;
            if (sample_en) begin
                // LSB arrives first, so shift in from the top.
                rx_reg <= {ds1302_io, rx_reg[7:1]};
            end
            if (state_next == ACK && op_read_reg) begin
                read_data_reg <= rx_reg;
            end
        end
    end

    assign ds1302_ce         = ce_reg;
    assign ds1302_sclk       = sclk_reg;
    assign ds1302_io         = io_oe_reg ? io_out_reg : 1'bz;
    assign bus.cmd_write_ack = wack_reg;
    assign bus.cmd_read_ack  = rack_reg;
    assign bus.read_data     = read_data_reg;

endmodule

// File: tb/tb_ds1302_bit_engine.sv
// ----------------------------------------------------------------------------
// tb_ds1302_bit_engine
// Directed stimulus with a scoreboard: each issued command pushes its
// expected ack (kind, cycle, read_data) and expected serial bits into queues;
// independent monitors pop and compare when the DUT presents an ack or an
// SCLK rise. A small DS1302 model answers reads.
// ----------------------------------------------------------------------------
module tb_ds1302_bit_engine;

    logic clk = 1'b0;
    logic rst;
    logic ds1302_ce;
    logic ds1302_sclk;
    wire  ds1302_io;

    ds1302_bit_engine_if bus ();

    ds1302_bit_engine #(
        .CLK_DIV  (2),
        .CE_SETUP (4),
        .CE_HOLD  (4),
        .CE_REC   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ds1302_ce   (ds1302_ce),
        .ds1302_sclk (ds1302_sclk),
        .ds1302_io   (ds1302_io)
    );

    always #5 clk = ~clk;

    // Hand-computed: 1 + 4 + 32*2 + 4 + 4
    localparam int TXN_CYC = 77;
    // CE high: 4 setup + 64 shift + 4 hold
    localparam int CE_HIGH = 72;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        int         when;
    } ack_exp_t;

    typedef struct {
        int slot;
        bit val;
    } bit_exp_t;

    ack_exp_t ack_q[$];
    bit_exp_t bit_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [7:0] cmd, input logic [7:0] dat, input bit with_data);
        for (int i = 0; i < 8; i++) bit_q.push_back('{i, cmd[i]});
        if (with_data)
            for (int i = 0; i < 8; i++) bit_q.push_back('{8 + i, dat[i]});
    endtask

    task automatic push_ack(input bit is_read, input logic [7:0] data, input int when);
        ack_q.push_back('{is_read, data, when});
    endtask

    // Waits for the scoreboard to drain down to 'left' entries, bounded.
    task automatic wait_acks(input int left, input int max_cyc);
        int n;
        n = 0;
        while (ack_q.size() > left && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (ack_q.size() > left) begin
            check("ack_timeout", ack_q.size(), left);
            ack_q.delete();
            bit_q.delete();
        end
    endtask

    // ---------------- DS1302 read model ----------------
    logic [7:0] model_byte = 8'h00;
    logic       model_oe   = 1'b0;
    logic       model_bit  = 1'b0;
    logic       m_prev_sclk = 1'b0;
    logic       m_is_rd = 1'b0;
    int         m_fall = 0;
    int         m_rise = 0;

    assign ds1302_io = model_oe ? model_bit : 1'bz;

    always @(negedge clk) begin
        if (!ds1302_ce) begin
            m_fall   = 0;
            m_rise   = 0;
            model_oe = 1'b0;
        end else begin
            if (!m_prev_sclk && ds1302_sclk) begin
                // Command bit0 tells a read from a write.
                if (m_rise == 0) m_is_rd = ds1302_io;
                m_rise++;
            end
            if (m_prev_sclk && !ds1302_sclk) m_fall++;
            if (m_is_rd && m_fall >= 8 && m_fall <= 15) begin
                model_oe  = 1'b1;
                model_bit = model_byte[3'(m_fall - 8)];
            end else begin
                model_oe = 1'b0;
            end
        end
        m_prev_sclk = ds1302_sclk;
    end

    // ---------------- Ack monitor ----------------
    ack_exp_t ack_e;
    always @(negedge clk) begin
        if (!rst && (bus.cmd_write_ack || bus.cmd_read_ack)) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.cmd_write_ack, bus.cmd_read_ack}, 0);
            end else begin
                ack_e = ack_q.pop_front();
                $display("TXN %s ack at cycle %0d read_data=%02h",
                         bus.cmd_read_ack ? "read " : "write", cyc, bus.read_data);
                check("ack_kind_read", {31'd0, bus.cmd_read_ack}, {31'd0, ack_e.is_read});
                check("ack_kind_write", {31'd0, bus.cmd_write_ack}, {31'd0, !ack_e.is_read});
                check("ack_cycle", cyc, ack_e.when);
                check("read_data", {24'd0, bus.read_data}, {24'd0, ack_e.data});
            end
        end
    end

    // ---------------- Serial bit monitor ----------------
    int       mon_slot = 0;
    logic     mon_prev_ce = 1'b0;
    logic     mon_prev_sclk = 1'b0;
    bit_exp_t bit_e;
    always @(negedge clk) begin
        if (rst) begin
            mon_slot = 0;
        end else begin
            if (ds1302_ce && !mon_prev_ce) mon_slot = 0;
            if (ds1302_sclk && !mon_prev_sclk) begin
                if (bit_q.size() > 0 && bit_q[0].slot == mon_slot) begin
                    bit_e = bit_q.pop_front();
                    check($sformatf("io_slot%0d", mon_slot), {31'd0, ds1302_io}, {31'd0, bit_e.val});
                end
                mon_slot++;
            end
        end
        mon_prev_ce   = ds1302_ce;
        mon_prev_sclk = ds1302_sclk;
    end

    // ---------------- CE timing monitor ----------------
    int   abort_cnt  = 0;
    int   abort_seen = 0;
    int   ce_hi = 0;
    int   ce_lo = 0;
    bit   ce_had_fall = 0;
    logic ce_prev = 1'b0;
    always @(negedge clk) begin
        if (ds1302_ce) begin
            if (!ce_prev) begin
                if (ce_had_fall) check("ce_low_gap_ge4", {31'd0, ce_lo >= 4}, 1);
                ce_hi = 0;
            end
            ce_hi++;
        end else begin
            if (ce_prev) begin
                if (abort_cnt == abort_seen) check("ce_high_len", ce_hi, CE_HIGH);
                abort_seen  = abort_cnt;
                ce_had_fall = 1;
                ce_lo       = 0;
            end
            ce_lo++;
        end
        ce_prev = ds1302_ce;
    end

    // ---------------- Stimulus ----------------
    int c;
    int n;
    initial begin
        rst            = 1'b1;
        bus.cmd_write  = 1'b0;
        bus.cmd_read   = 1'b0;
        bus.write_addr = 8'h00;
        bus.write_data = 8'h00;
        bus.read_addr  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_ce", {31'd0, ds1302_ce}, 0);
        check("rst_sclk", {31'd0, ds1302_sclk}, 0);
        check("rst_wack", {31'd0, bus.cmd_write_ack}, 0);
        check("rst_rack", {31'd0, bus.cmd_read_ack}, 0);
        check("rst_read_data", {24'd0, bus.read_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x80 <- 0x59; operands change right after latching.
        c = cyc;
        bus.write_addr = 8'h80;
        bus.write_data = 8'h59;
        bus.cmd_write  = 1'b1;
        push_ack(0, 8'h00, c + TXN_CYC);
        push_bits(8'h80, 8'h59, 1);
        @(negedge clk);
        bus.write_addr = 8'hFF;
        bus.write_data = 8'hFF;
        wait_acks(0, 200);
        bus.cmd_write = 1'b0;
        repeat (3) @(negedge clk);

        // Read 0x80 -> command 0x81, model returns 0x37.
        model_byte    = 8'h37;
        c = cyc;
        bus.read_addr = 8'h80;
        bus.cmd_read  = 1'b1;
        push_ack(1, 8'h37, c + TXN_CYC);
        push_bits(8'h81, 8'h00, 0);
        wait_acks(0, 200);
        bus.cmd_read = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous write 0x82<-0x3C and read 0x85; write wins.
        model_byte     = 8'h5A;
        c = cyc;
        bus.write_addr = 8'h82;
        bus.write_data = 8'h3C;
        bus.read_addr  = 8'h85;
        bus.cmd_write  = 1'b1;
        bus.cmd_read   = 1'b1;
        push_ack(0, 8'h37, c + TXN_CYC);
        push_ack(1, 8'h5A, c + TXN_CYC + 1 + TXN_CYC);
        push_bits(8'h82, 8'h3C, 1);
        push_bits(8'h85, 8'h00, 0);
        wait_acks(1, 200);
        bus.cmd_write = 1'b0;
        wait_acks(0, 200);
        bus.cmd_read = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back writes: drop at ack, re-assert next cycle with new operands.
        c = cyc;
        bus.write_addr = 8'h80;
        bus.write_data = 8'h11;
        bus.cmd_write  = 1'b1;
        push_ack(0, 8'h5A, c + TXN_CYC);
        push_bits(8'h80, 8'h11, 1);
        n = 0;
        while (!bus.cmd_write_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_ack_seen", {31'd0, bus.cmd_write_ack}, 1);
        bus.cmd_write = 1'b0;
        @(negedge clk);
        c = cyc;
        bus.write_addr = 8'h8D;  // bit0 forced low -> 0x8C on the wire
        bus.write_data = 8'hA5;
        bus.cmd_write  = 1'b1;
        push_ack(0, 8'h5A, c + TXN_CYC);
        push_bits(8'h8C, 8'hA5, 1);
        wait_acks(0, 200);
        bus.cmd_write = 1'b0;
        repeat (3) @(negedge clk);

        // Reset around slot 10 of a write: abandoned, no ack.
        c = cyc;
        bus.write_addr = 8'h8A;
        bus.write_data = 8'h77;
        bus.cmd_write  = 1'b1;
        push_ack(0, 8'h5A, c + TXN_CYC);
        push_bits(8'h8A, 8'h77, 1);
        repeat (46) @(negedge clk);
        #2;
        abort_cnt++;
        rst = 1'b1;
        #1;
        check("midrst_ce", {31'd0, ds1302_ce}, 0);
        check("midrst_sclk", {31'd0, ds1302_sclk}, 0);
        check("midrst_read_data", {24'd0, bus.read_data}, 0);
        check("midrst_wack", {31'd0, bus.cmd_write_ack}, 0);
        ack_q.delete();
        bit_q.delete();
        @(negedge clk);
        bus.cmd_write = 1'b0;
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // Fresh read after reset.
        model_byte    = 8'hC4;
        c = cyc;
        bus.read_addr = 8'h8A;
        bus.cmd_read  = 1'b1;
        push_ack(1, 8'hC4, c + TXN_CYC);
        push_bits(8'h8B, 8'h00, 0);
        wait_acks(0, 200);
        bus.cmd_read = 1'b0;
        repeat (5) @(negedge clk);

        check("bits_left", bit_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
